semi_auto_driver: RTL and testbench
===================================

SEMI_AUTO_DRIVER -- requirements
Module: semi_auto_driver

Interface
REQ-001 Parameter TURN_CYCLES, default 100_000_000, duration of a 90-degree turn in clk cycles (1 s at 100 MHz).
REQ-002 Parameter COOLDOWN_CYCLES, default 50_000_000, forced-forward interval after any turn, in clk cycles.
REQ-003 clk  input  1  the single system clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 enable  input  1  high while Mode equals semi-auto (3'b010); low forces IDLE.
REQ-006 front_detector, left_detector, right_detector, back_detector  input  1 each  1 = wall present, 0 = open.
REQ-007 btn_forward, btn_left, btn_right, btn_back  input  1 each  debounced single-cycle user direction requests.
REQ-008 sa_turn_left_signal, sa_turn_right_signal, sa_move_backward_signal, sa_move_forward_signal  output  1 each  drive commands to the mode multiplexer.
REQ-009 state_o  output  3  current FSM state encoding, for LEDs and debugging.

Function
REQ-010 The FSM SHALL have the states IDLE, FORWARD, JUNCTION, TURN_L, TURN_R, TURN_BACK and COOLDOWN.
REQ-011 Outputs SHALL be Moore-decoded from the registered state, and at most one output SHALL be high in any cycle.
- FORWARD and COOLDOWN: forward high.
- TURN_L and TURN_BACK: turn_left high.
- TURN_R: turn_right high.
- IDLE and JUNCTION: all outputs low.
REQ-012 IDLE SHALL move to FORWARD on the first edge at which enable is high.
REQ-013 FORWARD SHALL detect a junction when front_detector is 1, left_detector is 0, or right_detector is 0.
REQ-014 At a junction, if front, left and right detectors are all 1 (dead end), FORWARD SHALL go directly to TURN_BACK; otherwise it SHALL go to JUNCTION.
REQ-015 JUNCTION SHALL hold until it receives a valid button; a button is valid only if its direction is open.
- btn_forward valid → COOLDOWN.
- btn_left valid → TURN_L.
- btn_right valid → TURN_R.
- btn_back → TURN_BACK (always valid).
REQ-016 If several valid buttons are high in the same cycle, priority SHALL be forward > left > right > back.
REQ-017 Buttons for blocked directions, and all buttons outside JUNCTION, SHALL be ignored.
REQ-018 TURN_L and TURN_R SHALL last exactly TURN_CYCLES cycles; TURN_BACK SHALL last exactly 2*TURN_CYCLES cycles. Each then goes to COOLDOWN.
REQ-019 COOLDOWN SHALL last exactly COOLDOWN_CYCLES cycles, ignoring all detectors, then go to FORWARD.
REQ-020 Latency SHALL be one edge: an input sampled high at edge n changes the state, and therefore the outputs, after edge n.
REQ-021 The duration counter SHALL clear on every state entry and SHALL be wide enough for max(2*TURN_CYCLES, COOLDOWN_CYCLES) without wrap-around.
REQ-022 enable low in any state SHALL force IDLE at the next edge and clear the counter; this takes priority over every other transition.
REQ-023 back_detector SHALL be reported only through state/debug visibility, and SHALL NOT block TURN_BACK.

Reset
REQ-024 rst high at a clock edge SHALL set the state to IDLE, the counter to 0, all four outputs to 0 and state_o to IDLE's encoding.
REQ-025 rst SHALL take priority over enable and all other inputs, including mid-turn and mid-cooldown.

Structure
REQ-026 State encodings and the semi-auto Mode constant (3'b010) SHALL live in the shared car constants package; TURN_CYCLES and COOLDOWN_CYCLES SHALL remain module parameters.
REQ-027 One sub-module, cycle_timer, SHALL be instantiated: a parameterised up-counter with clear input and done flag. All other logic lives in semi_auto_driver.

Verification (TURN_CYCLES=4, COOLDOWN_CYCLES=3)
REQ-028 Assert rst, then enable=1 with all detectors showing walls left/right and front open → IDLE then FORWARD; forward=1 from the first edge after rst deasserts.
REQ-029 In FORWARD, set left_detector=0 → JUNCTION next edge with outputs 0. Pulse btn_right (right blocked) → no change. Pulse btn_left → turn_left=1 for exactly 4 cycles, then forward=1 for 3 COOLDOWN cycles, then FORWARD.
REQ-030 Dead end (front, left, right all 1) in FORWARD → TURN_BACK; turn_left=1 for exactly 8 cycles, then COOLDOWN.
REQ-031 In JUNCTION with all directions open, pulse btn_forward, btn_left and btn_right in the same cycle → COOLDOWN (forward wins); turn outputs never assert.
REQ-032 Drop enable during cycle 2 of TURN_R → IDLE next edge, outputs 0. Re-enable → FORWARD with the counter restarted at 0.
REQ-033 Assert rst during COOLDOWN with enable=1 → next edge all outputs 0 and state_o = IDLE; then FORWARD one edge after rst falls.

Source files
------------

// File: rtl/semi_auto_driver_pkg.sv
// Shared car constants: semi-auto FSM state encodings and mode value.
// Imported by the semi-auto driver and its bench.
package semi_auto_driver_pkg;

   localparam logic [2:0] MODE_SEMI_AUTO = 3'b010;

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_FORWARD   = 3'd1,
      S_JUNCTION  = 3'd2,
      S_TURN_L    = 3'd3,
      S_TURN_R    = 3'd4,
      S_TURN_BACK = 3'd5,
      S_COOLDOWN  = 3'd6
   } state_e;

   function automatic int unsigned max_u(
      input int unsigned a,
      input int unsigned b
   );
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/cycle_timer.sv
// Saturating up-counter with synchronous clear.
// done is high once the count has reached target.
module cycle_timer #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             clear,
   input  logic [WIDTH-1:0] target,
   output logic             done
);

   logic [WIDTH-1:0] count;

   assign done = (count >= target);

   // holding at target means an idle timer can never wrap
   always_ff @(posedge clk) begin
      if (clear)
         count <= '0;
      else if (!done)
         count <= count + WIDTH'(1);
   end

endmodule

// File: rtl/semi_auto_driver.sv
// Semi-autonomous driving FSM: follows the corridor, waits for a user
// direction at junctions, and times turns and post-turn cooldown.
module semi_auto_driver
   import semi_auto_driver_pkg::*;
#(
   parameter int unsigned TURN_CYCLES     = 100_000_000,
   parameter int unsigned COOLDOWN_CYCLES = 50_000_000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       enable,
   input  logic       front_detector,
   input  logic       left_detector,
   input  logic       right_detector,
   input  logic       back_detector,
   input  logic       btn_forward,
   input  logic       btn_left,
   input  logic       btn_right,
   input  logic       btn_back,
   output logic       sa_turn_left_signal,
   output logic       sa_turn_right_signal,
   output logic       sa_move_backward_signal,
   output logic       sa_move_forward_signal,
   output logic [2:0] state_o
);

   localparam int unsigned MAX_DUR =
      max_u(2 * TURN_CYCLES, COOLDOWN_CYCLES);
   localparam int unsigned CW = $clog2(MAX_DUR + 1);

   localparam logic [CW-1:0] T_TURN = CW'(TURN_CYCLES - 1);
   localparam logic [CW-1:0] T_BACK = CW'(2 * TURN_CYCLES - 1);
   localparam logic [CW-1:0] T_COOL = CW'(COOLDOWN_CYCLES - 1);

   state_e        state;
   state_e        state_next;
   logic [CW-1:0] target;
   logic          done;
   logic          clear;
   logic          junction;
   logic          dead_end;
   logic          back_open;

   assign junction = front_detector | ~left_detector | ~right_detector;
   assign dead_end = front_detector & left_detector & right_detector;
   // reversing never depends on the rear sensor; it is debug-only
   assign back_open = 1'b1 | back_detector;

   always_ff @(posedge clk) begin
      if (rst)
         state <= S_IDLE;
      else
         state <= state_next;
   end

   always_comb begin
      state_next = state;
      if (!enable) begin
         state_next = S_IDLE;
      end else begin
         unique case (state)
            S_IDLE:
               state_next = S_FORWARD;
            S_FORWARD:
               if (dead_end)
                  state_next = S_TURN_BACK;
               else if (junction)
                  state_next = S_JUNCTION;
            S_JUNCTION:
               if (btn_forward && !front_detector)
                  state_next = S_COOLDOWN;
               else if (btn_left && !left_detector)
                  state_next = S_TURN_L;
               else if (btn_right && !right_detector)
                  state_next = S_TURN_R;
               else if (btn_back && back_open)
                  state_next = S_TURN_BACK;
            S_TURN_L, S_TURN_R, S_TURN_BACK:
               if (done)
                  state_next = S_COOLDOWN;
            S_COOLDOWN:
               if (done)
                  state_next = S_FORWARD;
            default:
               state_next = S_IDLE;
         endcase
      end
   end

   always_comb begin
      target = T_COOL;
      unique case (state)
         S_TURN_L, S_TURN_R: target = T_TURN;
         S_TURN_BACK:        target = T_BACK;
         default:            target = T_COOL;
      endcase
   end

   // restart timing on every state entry
   assign clear = rst | ~enable | (state_next != state);

   cycle_timer #(
      .WIDTH (CW)
   ) u_timer (
      .clk    (clk),
      .clear  (clear),
      .target (target),
      .done   (done)
   );

   always_comb begin
      sa_turn_left_signal     = 1'b0;
      sa_turn_right_signal    = 1'b0;
      sa_move_backward_signal = 1'b0;
      sa_move_forward_signal  = 1'b0;
      unique case (state)
         S_FORWARD, S_COOLDOWN:  sa_move_forward_signal = 1'b1;
         S_TURN_L, S_TURN_BACK:  sa_turn_left_signal    = 1'b1;
         S_TURN_R:               sa_turn_right_signal   = 1'b1;
         default: ;
      endcase
   end

   assign state_o = state;

endmodule

// File: tb/tb_semi_auto_driver.sv
// Bench for semi_auto_driver: scripted table, corner sequences and
// randomized traffic against a countdown-based reference model.
module tb_semi_auto_driver;
   import semi_auto_driver_pkg::*;

   localparam int TURN = 4;
   localparam int COOL = 3;

   logic clk = 1'b0;
   logic rst, en, f, l, r, b, bf, bl, br, bb;
   logic tl_o, tr_o, bk_o, fw_o;
   logic [2:0] st_o;

   int n_tests = 0;
   int n_fail  = 0;

   state_e m_st = S_IDLE;
   int     m_rem = 0;

   always #5 clk = ~clk;

   semi_auto_driver #(
      .TURN_CYCLES     (TURN),
      .COOLDOWN_CYCLES (COOL)
   ) dut (
      .clk                     (clk),
      .rst                     (rst),
      .enable                  (en),
      .front_detector          (f),
      .left_detector           (l),
      .right_detector          (r),
      .back_detector           (b),
      .btn_forward             (bf),
      .btn_left                (bl),
      .btn_right               (br),
      .btn_back                (bb),
      .sa_turn_left_signal     (tl_o),
      .sa_turn_right_signal    (tr_o),
      .sa_move_backward_signal (bk_o),
      .sa_move_forward_signal  (fw_o),
      .state_o                 (st_o)
   );

   typedef struct {
      logic   rst, en, f, l, r, bf, bl, br, bb;
      state_e exp;
   } vec_t;

   vec_t vt[31];

   // {state, turn_left, turn_right, backward, forward}
   function automatic logic [6:0] expect_bits(input state_e s);
      logic fw, tl, tr;
      fw = (s == S_FORWARD) || (s == S_COOLDOWN);
      tl = (s == S_TURN_L) || (s == S_TURN_BACK);
      tr = (s == S_TURN_R);
      return {s, tl, tr, 1'b0, fw};
   endfunction

   function automatic int dur(input state_e s);
      if (s == S_TURN_BACK) return 2 * TURN;
      if (s == S_COOLDOWN)  return COOL;
      return TURN;
   endfunction

   task automatic go(input state_e s);
      m_st  = s;
      m_rem = dur(s);
   endtask

   task automatic model_step();
      if (rst || !en) begin
         m_st = S_IDLE;
      end else begin
         case (m_st)
            S_IDLE: m_st = S_FORWARD;
            S_FORWARD:
               if (f && l && r) go(S_TURN_BACK);
               else if (f || !l || !r) m_st = S_JUNCTION;
            S_JUNCTION:
               if (bf && !f) go(S_COOLDOWN);
               else if (bl && !l) go(S_TURN_L);
               else if (br && !r) go(S_TURN_R);
               else if (bb) go(S_TURN_BACK);
            default: begin
               m_rem--;
               if (m_rem == 0)
                  m_st = (m_st == S_COOLDOWN) ? S_FORWARD : S_COOLDOWN;
               if (m_rem == 0 && m_st == S_COOLDOWN)
                  m_rem = COOL;
            end
         endcase
      end
   endtask

   task automatic chk(input string nm, input state_e exp);
      logic [6:0] got;
      got = {st_o, tl_o, tr_o, bk_o, fw_o};
      n_tests++;
      if (got !== expect_bits(exp)) begin
         n_fail++;
         $display("FAIL %s: got state/outs %b, want %b",
                  nm, got, expect_bits(exp));
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
      chk("model", m_st);
   endtask

   function automatic vec_t v(
      input logic rs, e, ff, ll, rr, xf, xl, xr, xb,
      input state_e x
   );
      vec_t t;
      t.rst = rs; t.en = e; t.f = ff; t.l = ll; t.r = rr;
      t.bf = xf; t.bl = xl; t.br = xr; t.bb = xb; t.exp = x;
      return t;
   endfunction

   initial begin
      {rst, en, f, l, r, b, bf, bl, br, bb} = '0;
      rst = 1'b1;

      //            rst en f l r bf bl br bb  expected
      vt[0]  = v(1, 1, 0, 1, 1, 0, 0, 0, 0, S_IDLE);
      vt[1]  = v(0, 1, 0, 1, 1, 0, 0, 0, 0, S_FORWARD);
      vt[2]  = v(0, 1, 0, 1, 1, 0, 0, 0, 0, S_FORWARD);
      vt[3]  = v(0, 1, 0, 0, 1, 0, 0, 0, 0, S_JUNCTION);
      vt[4]  = v(0, 1, 0, 0, 1, 0, 0, 1, 0, S_JUNCTION);
      vt[5]  = v(0, 1, 0, 0, 1, 0, 1, 0, 0, S_TURN_L);
      vt[6]  = v(0, 1, 0, 0, 1, 0, 0, 0, 0, S_TURN_L);
      vt[7]  = v(0, 1, 0, 0, 1, 0, 0, 0, 0, S_TURN_L);
      vt[8]  = v(0, 1, 0, 0, 1, 0, 0, 0, 0, S_TURN_L);
      vt[9]  = v(0, 1, 0, 1, 1, 0, 0, 0, 0, S_COOLDOWN);
      vt[10] = v(0, 1, 1, 0, 0, 0, 0, 0, 0, S_COOLDOWN);
      vt[11] = v(0, 1, 0, 1, 1, 0, 0, 0, 0, S_COOLDOWN);
      vt[12] = v(0, 1, 0, 1, 1, 0, 0, 0, 0, S_FORWARD);
      vt[13] = v(0, 1, 0, 1, 1, 0, 0, 0, 0, S_FORWARD);
      vt[14] = v(0, 1, 1, 1, 1, 0, 0, 0, 0, S_TURN_BACK);
      for (int i = 15; i <= 21; i++)
         vt[i] = v(0, 1, 0, 1, 1, 0, 0, 0, 0, S_TURN_BACK);
      vt[22] = v(0, 1, 0, 1, 1, 0, 0, 0, 0, S_COOLDOWN);
      vt[23] = v(0, 1, 0, 1, 1, 0, 0, 0, 0, S_COOLDOWN);
      vt[24] = v(0, 1, 0, 1, 1, 0, 0, 0, 0, S_COOLDOWN);
      vt[25] = v(0, 1, 0, 1, 1, 0, 0, 0, 0, S_FORWARD);
      vt[26] = v(0, 1, 0, 0, 0, 0, 0, 0, 0, S_JUNCTION);
      vt[27] = v(0, 1, 0, 0, 0, 1, 1, 1, 0, S_COOLDOWN);
      vt[28] = v(0, 1, 0, 1, 1, 0, 0, 0, 0, S_COOLDOWN);
      vt[29] = v(0, 1, 0, 1, 1, 0, 0, 0, 0, S_COOLDOWN);
      vt[30] = v(0, 1, 0, 1, 1, 0, 0, 0, 0, S_FORWARD);

      foreach (vt[i]) begin
         rst = vt[i].rst; en = vt[i].en;
         f = vt[i].f; l = vt[i].l; r = vt[i].r;
         bf = vt[i].bf; bl = vt[i].bl;
         br = vt[i].br; bb = vt[i].bb;
         tick();
         chk($sformatf("vec%0d", i), vt[i].exp);
      end
      {bf, bl, br, bb} = '0;

      // enable drop in the second TURN_R cycle, then a full re-turn
      r = 1'b0; tick(); chk("tr_junc", S_JUNCTION);
      br = 1'b1; tick(); chk("tr_c1", S_TURN_R);
      br = 1'b0; tick(); chk("tr_c2", S_TURN_R);
      en = 1'b0; tick(); chk("en_drop", S_IDLE);
      en = 1'b1; r = 1'b1; tick(); chk("re_en", S_FORWARD);
      r = 1'b0; tick(); chk("tr2_junc", S_JUNCTION);
      br = 1'b1; tick(); br = 1'b0;
      for (int i = 0; i < TURN - 1; i++) begin
         tick(); chk("tr2_hold", S_TURN_R);
      end
      r = 1'b1; tick(); chk("tr2_end", S_COOLDOWN);

      // reset in the middle of cooldown
      tick(); chk("cd_mid", S_COOLDOWN);
      rst = 1'b1; tick(); chk("cd_rst", S_IDLE);
      rst = 1'b0; tick(); chk("post_rst", S_FORWARD);

      for (int i = 0; i < 4000; i++) begin
         rst = ($urandom_range(0, 99) == 0);
         en  = ($urandom_range(0, 49) != 0);
         f   = ($urandom_range(0, 3) == 0);
         l   = ($urandom_range(0, 3) != 0);
         r   = ($urandom_range(0, 3) != 0);
         b   = 1'($urandom);
         bf  = ($urandom_range(0, 3) == 0);
         bl  = ($urandom_range(0, 3) == 0);
         br  = ($urandom_range(0, 3) == 0);
         bb  = ($urandom_range(0, 5) == 0);
         tick();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
